intra_recon_sum: RTL and testbench

//  Reconstruction stage directly downstream of intra prediction: joins one 4x4 prediction block with its 4x4

---
 rtl/intra_recon_sum_pkg.sv | 16 +
 rtl/intra_recon_sum_if.sv | 38 +++
 rtl/recon_clip8.sv | 19 +
 rtl/intra_recon_sum.sv | 133 +++++++++++++
 tb/tb_intra_recon_sum.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/intra_recon_sum_pkg.sv
// Shared types and defaults for the intra reconstruction stage: residual width
// default, block geometry and the join FSM state encoding.
package intra_recon_sum_pkg;

    localparam int RECON_RES_W = 9;
    localparam int RECON_NPIX  = 16;
    localparam int RECON_BLK_W = 5;

    typedef enum logic [1:0] {
        RECON_IDLE      = 2'd0,
        RECON_HAVE_PRED = 2'd1,
        RECON_HAVE_RES  = 2'd2,
        RECON_CALC      = 2'd3
    } recon_state_e;

endpackage

// File: rtl/intra_recon_sum_if.sv
// Block-level bus between intra prediction / residual producers and the
// reconstruction stage. res_zero exists only when RECON_ZERO_SKIP_EN is defined.
interface intra_recon_sum_if #(
    parameter int RES_W = 9
);
    // Valid/ready contract: pred_valid, res_valid and sum_valid are one-cycle
    // pulses with no back-pressure; data is valid only in the cycle of its pulse.
    logic [4:0]             blk4x4_counter;
    logic                   pred_valid;
    logic [15:0][7:0]       intra_pred;
    logic                   res_valid;
    logic [15:0][RES_W-1:0] res;
`ifdef RECON_ZERO_SKIP_EN
    logic                   res_zero;
`endif
    logic [15:0][7:0]       sum;
    logic [4:0]             sum_blk4x4;
    logic                   sum_valid;
    logic [31:0]            sum_right_colum;
    logic [31:0]            sum_bottom_row;

    modport master (
`ifdef RECON_ZERO_SKIP_EN
        output res_zero,
`endif
        output blk4x4_counter, pred_valid, intra_pred, res_valid, res,
        input  sum, sum_blk4x4, sum_valid, sum_right_colum, sum_bottom_row
    );

    modport slave (
`ifdef RECON_ZERO_SKIP_EN
        input  res_zero,
`endif
        input  blk4x4_counter, pred_valid, intra_pred, res_valid, res,
        output sum, sum_blk4x4, sum_valid, sum_right_colum, sum_bottom_row
    );

endinterface

// File: rtl/recon_clip8.sv
// Saturates a signed W-bit sum to an 8-bit pixel: negative -> 0, above 255 -> 255.
module recon_clip8 #(
    parameter int W = 10
) (
    input  logic signed [W-1:0] d_i,
    output logic        [7:0]   q_o
);

    always_comb begin
        if (d_i[W-1]) begin
            q_o = 8'd0;
        end else if (|d_i[W-2:8]) begin
            q_o = 8'hFF;
        end else begin
            q_o = d_i[7:0];
        end
    end

endmodule

// File: rtl/intra_recon_sum.sv
// Joins a 4x4 prediction with its residual, adds and clips to 0..255, and returns
// the right column / bottom row to intra prediction. Option: RECON_ZERO_SKIP_EN.
module intra_recon_sum
    import intra_recon_sum_pkg::*;
#(
    parameter int RES_W = RECON_RES_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    intra_recon_sum_if.slave   bus,
    output logic               proto_err,
    output recon_state_e       state_dbg_o
);

    localparam int SW = RES_W + 1;

    recon_state_e              state_q, state_d;
    logic                      proto_err_q, proto_err_d;
    logic                      join_w;
    logic                      zero_skip_w;
    logic [15:0][7:0]          pred_q;
    logic [15:0][RES_W-1:0]    res_q;
    logic [4:0]                blk_q;
    logic [15:0][7:0]          pred_op;
    logic [15:0][RES_W-1:0]    res_op;
    logic [4:0]                blk_op;
    logic signed [SW-1:0]      sum_d  [RECON_NPIX];
    logic signed [SW-1:0]      s1_q   [RECON_NPIX];
    logic [4:0]                s1_blk_q;
    logic [15:0][7:0]          clip_w;
    logic [15:0][7:0]          sum_q;
    logic [4:0]                sum_blk_q;
    logic                      sum_valid_q;

`ifdef RECON_ZERO_SKIP_EN
    // A zero-residual prediction only short-cuts the join when nothing is pending.
    assign zero_skip_w = bus.pred_valid & bus.res_zero &
                         ((state_q == RECON_IDLE) || (state_q == RECON_CALC));
`else
    assign zero_skip_w = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        proto_err_d = proto_err_q;
        join_w      = 1'b0;
        case (state_q)
            RECON_HAVE_PRED: begin
                if (bus.pred_valid) proto_err_d = 1'b1;
                if (bus.res_valid)  join_w      = 1'b1;
            end
            RECON_HAVE_RES: begin
                if (bus.res_valid)  proto_err_d = 1'b1;
                if (bus.pred_valid) join_w      = 1'b1;
            end
            default: begin
                if (zero_skip_w || (bus.pred_valid && bus.res_valid)) begin
                    join_w = 1'b1;
                end else if (bus.pred_valid) begin
                    state_d = RECON_HAVE_PRED;
                end else if (bus.res_valid) begin
                    state_d = RECON_HAVE_RES;
                end else begin
                    state_d = RECON_IDLE;
                end
            end
        endcase
        if (join_w) state_d = RECON_CALC;
    end

    // Operands at the join: a pulse arriving this cycle wins over the held copy.
    always_comb begin
        blk_op = bus.pred_valid ? bus.blk4x4_counter : blk_q;
        for (int i = 0; i < RECON_NPIX; i++) begin
            pred_op[i] = bus.pred_valid ? bus.intra_pred[i] : pred_q[i];
            res_op[i]  = zero_skip_w ? '0 : (bus.res_valid ? bus.res[i] : res_q[i]);
            sum_d[i]   = $signed({{(SW-8){1'b0}}, pred_op[i]}) +
                         $signed({res_op[i][RES_W-1], res_op[i]});
        end
    end

    for (genvar g = 0; g < RECON_NPIX; g++) begin : g_clip
        recon_clip8 #(.W(SW)) u_clip (
            .d_i (s1_q[g]),
            .q_o (clip_w[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RECON_IDLE;
            proto_err_q <= 1'b0;
            pred_q      <= '0;
            res_q       <= '0;
            blk_q       <= '0;
            s1_blk_q    <= '0;
            sum_q       <= '0;
            sum_blk_q   <= '0;
            sum_valid_q <= 1'b0;
            for (int i = 0; i < RECON_NPIX; i++) s1_q[i] <= '0;
        end else if (ena) begin
            state_q     <= state_d;
            proto_err_q <= proto_err_d;
            if (bus.pred_valid) begin
                pred_q <= bus.intra_pred;
                blk_q  <= bus.blk4x4_counter;
            end
            if (bus.res_valid) res_q <= bus.res;
            if (join_w) begin
                s1_blk_q <= blk_op;
                for (int i = 0; i < RECON_NPIX; i++) s1_q[i] <= sum_d[i];
            end
            // Stage 1 holds valid sums exactly while the FSM sits in CALC.
            sum_valid_q <= (state_q == RECON_CALC);
            if (state_q == RECON_CALC) begin
                sum_q     <= clip_w;
                sum_blk_q <= s1_blk_q;
            end
        end else begin
            sum_valid_q <= 1'b0;
        end
    end

    assign bus.sum             = sum_q;
    assign bus.sum_blk4x4      = sum_blk_q;
    assign bus.sum_valid       = sum_valid_q;
    assign bus.sum_right_colum = {sum_q[15], sum_q[11], sum_q[7], sum_q[3]};
    assign bus.sum_bottom_row  = sum_q[15:12];
    assign proto_err           = proto_err_q;
    assign state_dbg_o         = state_q;

endmodule

// File: tb/tb_intra_recon_sum.sv
// Directed plus randomized bench for intra_recon_sum; the zero-skip step is built
// only when RECON_ZERO_SKIP_EN is defined.
module tb_intra_recon_sum;
  import intra_recon_sum_pkg::*;

  localparam int W = 133;

  logic clk;
  logic rst_n;
  logic ena;
  logic proto_err;
  recon_state_e state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  intra_recon_sum_if #(.RES_W(9)) bus ();

  intra_recon_sum dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .bus         (bus),
    .proto_err   (proto_err),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [15:0][7:0] model(input logic [15:0][7:0] p,
                                             input logic [15:0][8:0] r);
    logic [15:0][7:0] o;
    int s;
    for (int i = 0; i < 16; i++) begin
      s = int'(p[i]) + int'($signed(r[i]));
      if (s < 0) o[i] = 8'd0;
      else if (s > 255) o[i] = 8'd255;
      else o[i] = 8'(s);
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input bit dp, input bit dr, input logic [15:0][7:0] p,
                      input logic [15:0][8:0] r, input logic [4:0] b);
    @(posedge clk); #1;
    bus.pred_valid = dp;
    bus.res_valid  = dr;
    if (dp) begin
      bus.intra_pred     = p;
      bus.blk4x4_counter = b;
    end
    if (dr) bus.res = r;
    @(posedge clk); #1;
    bus.pred_valid = 1'b0;
    bus.res_valid  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Waits (bounded) for sum_valid and checks latency and payload against exp_q.
  task automatic expect_out(input string tag, input int lat);
    logic [W-1:0] e;
    logic [15:0][7:0] es;
    int k;
    bit seen;
    e = exp_q.pop_front();
    es = e[127:0];
    seen = 0;
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.sum_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    check({tag, " latency"}, 128'(k), 128'(lat));
    if (seen) begin
      check({tag, " sums"}, bus.sum, es);
      check({tag, " blk"}, 128'(bus.sum_blk4x4), 128'(e[132:128]));
      check({tag, " right"}, 128'(bus.sum_right_colum), 128'({es[15], es[11], es[7], es[3]}));
      check({tag, " bottom"}, 128'(bus.sum_bottom_row), 128'({es[15], es[14], es[13], es[12]}));
    end
  endtask

  function automatic logic [15:0][7:0] fillp(input logic [7:0] v);
    logic [15:0][7:0] o;
    for (int i = 0; i < 16; i++) o[i] = v;
    return o;
  endfunction

  function automatic logic [15:0][8:0] fillr(input int v);
    logic [15:0][8:0] o;
    for (int i = 0; i < 16; i++) o[i] = 9'(v);
    return o;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0][7:0] p, p2;
    logic [15:0][8:0] r;
    logic [4:0] b;
    int order, gap, seen;

    rst_n = 1'b0;
    ena = 1'b1;
    bus.pred_valid = 1'b0;
    bus.res_valid = 1'b0;
    bus.intra_pred = '0;
    bus.res = '0;
    bus.blk4x4_counter = '0;
`ifdef RECON_ZERO_SKIP_EN
    bus.res_zero = 1'b0;
`endif
    idle(2);
    @(negedge clk);
    check("reset sum", bus.sum, '0);
    check("reset valid", 128'(bus.sum_valid), 128'(0));
    check("reset right", 128'(bus.sum_right_colum), 128'(0));
    check("reset proto", 128'(proto_err), 128'(0));
    check("reset state", 128'(state_dbg), 128'(RECON_IDLE));
    rst_n = 1'b1;

    // pred 100, residual +20 three cycles later
    p = fillp(8'd100); r = fillr(20); b = 5'd3;
    exp_q.push_back({b, model(p, r)});
    send(1, 0, p, r, b);
    idle(2);
    send(0, 1, p, r, b);
    expect_out("basic", 2);
    check("basic right const", 128'(bus.sum_right_colum), 128'(32'h78787878));

    // clipping corners
    p = fillp(8'd250); r = fillr(30); b = 5'd4;
    exp_q.push_back({b, model(p, r)});
    send(1, 1, p, r, b);
    expect_out("clip high", 2);
    check("clip high const", bus.sum[0], 8'd255);
    p = fillp(8'd5); r = fillr(-40); b = 5'd5;
    exp_q.push_back({b, model(p, r)});
    send(1, 1, p, r, b);
    expect_out("clip low", 2);
    p = fillp(8'd255); r = fillr(-256); b = 5'd6;
    exp_q.push_back({b, model(p, r)});
    send(1, 1, p, r, b);
    expect_out("clip -256", 2);
    check("clip -256 const", bus.sum[5], 8'd0);

    // raster prediction, same-cycle join, zero residual
    for (int i = 0; i < 16; i++) p[i] = 8'(i);
    r = fillr(0); b = 5'd17;
    exp_q.push_back({b, model(p, r)});
    send(1, 1, p, r, b);
    expect_out("raster", 2);
    check("raster bottom const", 128'(bus.sum_bottom_row), 128'(32'h0F0E0D0C));
    check("raster right const", 128'(bus.sum_right_colum), 128'(32'h0F0B0703));

    // residual first, ena low 4 cycles with a pred pulse that must be ignored
    p = fillp(8'd60); r = fillr(-7); b = 5'd9;
    exp_q.push_back({b, model(p, r)});
    send(0, 1, p, r, b);
    ena = 1'b0;
    bus.pred_valid = 1'b1;
    bus.intra_pred = fillp(8'd1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.sum_valid !== 1'b0) seen++;
    end
    check("ena low no valid", 128'(seen), 128'(0));
    check("ena low state", 128'(state_dbg), 128'(RECON_HAVE_RES));
    @(posedge clk); #1;
    bus.pred_valid = 1'b0;
    ena = 1'b1;
    send(1, 0, p, r, b);
    expect_out("ena resume", 2);

    // pipeline frozen by ena between join and output
    p = fillp(8'd33); r = fillr(11); b = 5'd21;
    exp_q.push_back({b, model(p, r)});
    send(1, 1, p, r, b);
    ena = 1'b0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.sum_valid !== 1'b0) seen++;
    end
    check("freeze no valid", 128'(seen), 128'(0));
    @(posedge clk); #1;
    ena = 1'b1;
    expect_out("freeze resume", 2);

    // two predictions without residual: sticky error, second prediction wins
    p = fillp(8'd10); p2 = fillp(8'd200); r = fillr(5); b = 5'd12;
    exp_q.push_back({5'd13, model(p2, r)});
    send(1, 0, p, r, b);
    send(1, 0, p2, r, 5'd13);
    @(negedge clk);
    check("proto set", 128'(proto_err), 128'(1));
    send(0, 1, p, r, b);
    expect_out("proto join", 2);
    idle(2);
    @(negedge clk);
    check("proto sticky", 128'(proto_err), 128'(1));

`ifdef RECON_ZERO_SKIP_EN
    p = fillp(8'd77); r = fillr(100); b = 5'd2;
    exp_q.push_back({b, fillp(8'd77)});
    @(posedge clk); #1;
    bus.pred_valid = 1'b1;
    bus.res_zero = 1'b1;
    bus.intra_pred = p;
    bus.blk4x4_counter = b;
    @(posedge clk); #1;
    bus.pred_valid = 1'b0;
    bus.res_zero = 1'b0;
    expect_out("zero skip", 2);
`endif

    // reset while holding a prediction
    p = fillp(8'd90); r = fillr(3); b = 5'd7;
    send(1, 0, p, r, b);
    @(negedge clk);
    check("pre-reset state", 128'(state_dbg), 128'(RECON_HAVE_PRED));
    rst_n = 1'b0;
    #2;
    check("mid reset sum", bus.sum, '0);
    check("mid reset proto", 128'(proto_err), 128'(0));
    check("mid reset bottom", 128'(bus.sum_bottom_row), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(0, 1, p, r, b);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.sum_valid !== 1'b0) seen++;
    end
    check("post reset no join", 128'(seen), 128'(0));
    exp_q.push_back({b, model(p, r)});
    send(1, 0, p, r, b);
    expect_out("post reset join", 2);

    // randomized blocks in random arrival order
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 16; i++) begin
        p[i] = 8'($urandom_range(0, 255));
        r[i] = 9'($urandom_range(0, 511));
      end
      b = 5'($urandom_range(0, 23));
      order = $urandom_range(0, 2);
      gap = $urandom_range(0, 3);
      exp_q.push_back({b, model(p, r)});
      if (order == 0) begin
        send(1, 1, p, r, b);
      end else if (order == 1) begin
        send(1, 0, p, r, b);
        idle(gap);
        send(0, 1, p, r, b);
      end else begin
        send(0, 1, p, r, b);
        idle(gap);
        send(1, 0, p, r, b);
      end
      expect_out("random", 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
